// File: rtl/button_conditioner.sv
// Turns a raw, bouncing, asynchronous push-button level into a debounced level
// plus single-cycle press / release / long-press event pulses.
module button_conditioner #(
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned DEBOUNCE_TIME_IN_MS         = 10,
  parameter int unsigned LONG_PRESS_TIME_IN_MS       = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  // Products are formed in 64 bits: a 100 MHz clock times 1000 ms overflows 32.
  localparam longint unsigned DEB_PRODUCT  = 64'(BOARD_CLOCK_FREQUENCY_IN_HZ) * 64'(DEBOUNCE_TIME_IN_MS);
  localparam longint unsigned LONG_PRODUCT = 64'(BOARD_CLOCK_FREQUENCY_IN_HZ) * 64'(LONG_PRESS_TIME_IN_MS);
  localparam int unsigned DEBOUNCE_CYCLES   = 32'(DEB_PRODUCT / 64'd1000);
  localparam int unsigned LONG_PRESS_CYCLES = 32'(LONG_PRODUCT / 64'd1000);

  localparam int CNT_W  = (DEBOUNCE_CYCLES < 1)   ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (LONG_PRESS_CYCLES < 1) ? 1 : $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long_press
    $error("button_conditioner: LONG_PRESS_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic              sync0_q, sync1_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync0_q   <= btn_in_i;
      sync1_q   <= sync0_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    // Hold time accrues while the debounced level is high, saturating so the
    // long-press pulse can fire only once per press.
    if (level_q && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
      long_d = (hold_q == (HOLD_MAX - HOLD_ONE));
    end

    unique case (state_q)
      IDLE: begin
        if (sync1_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync1_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
          long_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync1_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high resumes the press without restarting hold time.
        if (sync1_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Converts a raw, asynchronous, bouncing push-button level into clean single-cycle event pulses and a debounced level for the stopwatch control logic. It is the input-side counterpart of the tick-to-toggle LED path: that path turns periodic ticks into a toggling level, and this block turns level changes into ticks. One instance sits behind each board button (start/stop, lap, reset) and feeds the stopwatch FSM.

## Interface
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, frequency of clk.
- DEBOUNCE_TIME_IN_MS, 10, time the synchronized input must be stable before the debounced level changes.
- LONG_PRESS_TIME_IN_MS, 1000, hold time after the debounced rise that raises long_press.
- Derived: DEBOUNCE_CYCLES = BOARD_CLOCK_FREQUENCY_IN_HZ * DEBOUNCE_TIME_IN_MS / 1000, and LONG_PRESS_CYCLES computed the same way. Both must be ≥ 1; otherwise elaboration fails.

Ports:
- clk, input, 1, system clock. This is the only clock.
- rst, input, 1, reset. It is synchronous and active-high.
- btn_in, input, 1, raw button level. It is asynchronous to clk and active-high.
- level, output, 1, debounced button level.
- press, output, 1, one-cycle pulse on each debounced rise.
- release, output, 1, one-cycle pulse on each debounced fall.
- long_press, output, 1, one-cycle pulse when the button has been held for LONG_PRESS_CYCLES.

## Operation
- **Synchronizer.** btn_in passes through two flops, sync0 then sync1. Only sync1 is used downstream.
- **FSM.** States are IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
  - IDLE, with level = 0: if sync1 = 1, go to PRESS_WAIT and set cnt = 1.
  - PRESS_WAIT:
    - If sync1 = 0, return to IDLE with no output.
    - Else if cnt = DEBOUNCE_CYCLES, go to PRESSED, set level = 1, pulse press and clear hold_cnt.
    - Else increment cnt.
  - PRESSED, with level = 1: if sync1 = 0, go to RELEASE_WAIT and set cnt = 1.
  - RELEASE_WAIT: this state mirrors PRESS_WAIT.
    - If sync1 = 1, return to PRESSED. hold_cnt keeps running and is not cleared.
    - Else if cnt = DEBOUNCE_CYCLES, go to IDLE, set level = 0 and pulse release.
    - Else increment cnt.
- **Debounce counter (cnt).** Width is $clog2(DEBOUNCE_CYCLES+1). It never exceeds DEBOUNCE_CYCLES. Any bounce during a WAIT state aborts the change; a new full window is needed.
- **Hold counter (hold_cnt).** Width is $clog2(LONG_PRESS_CYCLES+1).
  - It increments every cycle while level = 1.
  - It saturates at LONG_PRESS_CYCLES.
  - long_press pulses once, on the cycle hold_cnt reaches LONG_PRESS_CYCLES. It never repeats within one press.
  - A release pulse still follows a long press.
- **Output exclusivity.** press, release and long_press are each high for exactly one cycle per event. press and release are never high in the same cycle.

## Timing
- **Reset (rst = 1 at a clk edge):**
  - sync0 = sync1 = 0, state = IDLE, cnt = 0, hold_cnt = 0.
  - level = press = release = long_press = 0.
  - This applies mid-operation: an in-progress WAIT or a pending long_press is discarded.
- **Button held through reset:** it is detected as a fresh press after the full latency below, counted from the first post-reset edge.
- **Press latency:** btn_in goes high and stays high. Call the first edge that samples it high edge 1.
  - sync1 = 1 after edge 2.
  - PRESS_WAIT is entered at edge 3.
  - level and press are high after edge DEBOUNCE_CYCLES+3.
  - The same latency applies to release.
- **Long-press latency:** long_press is high LONG_PRESS_CYCLES cycles after the cycle press was high.
- **Glitches:** a glitch shorter than DEBOUNCE_CYCLES+1 cycles on sync1 produces no output.
- **Outputs:** all outputs are registered. There are no combinational paths from btn_in.

## Test plan
All scenarios use BOARD_CLOCK_FREQUENCY_IN_HZ = 10_000, DEBOUNCE_TIME_IN_MS = 1 and LONG_PRESS_TIME_IN_MS = 5, giving DEBOUNCE_CYCLES = 10 and LONG_PRESS_CYCLES = 50.

- **Clean press:** btn_in goes high at edge 1 and holds for 30 cycles, then goes low → press and level rise after edge 13; release pulses 13 cycles after the fall; long_press is never asserted.
- **Bounce:** btn_in toggles every 3 cycles for 40 cycles, then holds high → exactly one press, 13 cycles after the final rise; no release occurs.
- **Long press:** btn_in is held high for 100 cycles → press at cycle 13, long_press exactly once at cycle 63, release 13 cycles after the fall.
- **Release glitch:** while pressed, btn_in goes low for 5 cycles and then returns high → no release pulse; level stays 1; long_press still fires at cycle 63 counted from the original press.
- **Mid-operation reset:** while btn_in is held high, assert rst for 1 cycle during PRESS_WAIT and again at hold_cnt = 40 → all outputs are 0 the cycle after reset; press re-fires 13 cycles after the reset deasserts; no stale long_press appears.
- **Minimal pulse:** a btn_in high pulse of exactly 11 cycles → one press and one release. A pulse of 10 cycles → no output.
